// File: rtl/sprite_anim_pkg.sv
// Shared types and constants for the sprite animation sequencer.
// Sprite sheet layout: every animation mode owns a group of four
// consecutive frame indices. base_of() returns the first index of a group.
package sprite_anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RUN  = 2'd2,
    JUMP = 2'd3
  } anim_mode_t;

  localparam logic [3:0] IDLE_BASE        = 4'd0;
  localparam logic [3:0] WALK_BASE        = 4'd4;
  localparam logic [3:0] RUN_BASE         = 4'd8;
  localparam logic [3:0] JUMP_BASE        = 4'd12;
  localparam int         FRAMES_PER_GROUP = 4;

  function automatic logic [3:0] base_of(input anim_mode_t m);
    logic [3:0] b;
    case (m)
      IDLE:    b = IDLE_BASE;
      WALK:    b = WALK_BASE;
      RUN:     b = RUN_BASE;
      default: b = JUMP_BASE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sprite_anim_sequencer_frame_step_div.sv
// Frame divider: counts frame_tick pulses and emits a one-cycle step pulse
// on every FRAMES_PER_STEP-th tick.
// Ports:
//   clk        in  clock
//   reset      in  synchronous active-high reset, counter -> 0
//   clear      in  restart the count (takes priority over frame_tick)
//   frame_tick in  one-cycle pulse per video frame
//   step       out one-cycle pulse, combinational from the qualifying tick
module frame_step_div #(
  parameter int FRAMES_PER_STEP = 6,
  parameter int DIV_W           = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic frame_tick,
  output logic step
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(FRAMES_PER_STEP - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_hit;

  assign w_hit = frame_tick && (r_div_cnt == LAST);
  // A clear in the same cycle discards the tick entirely.
  assign step  = w_hit && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_div_cnt <= '0;
    end else if (frame_tick) begin
      r_div_cnt <= w_hit ? '0 : r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Sprite animation sequencer: produces the 4-bit sprite frame index for the
// sprite sheet position mux. Looping modes (IDLE/WALK/RUN) cycle through
// their 4-frame group; JUMP plays 12..15 once, then returns to the looping
// mode that was active when the jump was accepted.
// Handshake: a command transfers when cmd_valid && cmd_ready; cmd_ready is
// low only while a jump plays, and commands offered then are dropped.
// Ports:
//   clk          in  clock
//   reset        in  synchronous active-high reset
//   frame_tick   in  one pulse per video frame
//   cmd_valid    in  command present
//   cmd          in  0=IDLE 1=WALK 2=RUN 3=JUMP
//   cmd_ready    out command can be accepted (mode != JUMP)
//   sprite_state out current frame index (registered)
//   anim_wrap    out one-cycle pulse when a loop wraps or a jump ends
module sprite_anim_sequencer
  import sprite_anim_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6,
  parameter int DIV_W           = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic [3:0] sprite_state,
  output logic       anim_wrap
);

  anim_mode_t r_mode, r_ret_mode;
  logic [3:0] r_sprite_state;
  logic       r_anim_wrap;

  anim_mode_t w_mode_nxt, w_ret_nxt, w_cmd;
  logic [3:0] w_state_nxt;
  logic       w_wrap_nxt;
  logic       w_accept;
  logic       w_effective;
  logic       w_step;
  logic       w_loop_last;

  assign w_cmd     = anim_mode_t'(cmd);
  assign cmd_ready = (r_mode != JUMP);
  assign w_accept  = cmd_valid && cmd_ready;
  // Re-issuing the current looping mode is a no-op: it must not restart
  // the divider. Any accepted command still swallows a coincident tick.
  assign w_effective = w_accept && ((w_cmd == JUMP) || (w_cmd != r_mode));
  assign w_loop_last = (r_sprite_state[1:0] == 2'(FRAMES_PER_GROUP - 1));

  frame_step_div #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP),
    .DIV_W           (DIV_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_effective),
    .frame_tick (frame_tick && !w_accept),
    .step       (w_step)
  );

  always_comb begin
    w_mode_nxt  = r_mode;
    w_ret_nxt   = r_ret_mode;
    w_state_nxt = r_sprite_state;
    w_wrap_nxt  = 1'b0;
    if (w_effective) begin
      if (w_cmd == JUMP) begin
        w_ret_nxt   = r_mode;
        w_mode_nxt  = JUMP;
        w_state_nxt = JUMP_BASE;
      end else begin
        w_mode_nxt  = w_cmd;
        w_state_nxt = base_of(w_cmd);
      end
    end else if (w_step) begin
      if (r_mode == JUMP) begin
        if (r_sprite_state == JUMP_BASE + 4'(FRAMES_PER_GROUP - 1)) begin
          w_mode_nxt  = r_ret_mode;
          w_state_nxt = base_of(r_ret_mode);
          w_wrap_nxt  = 1'b1;
        end else begin
          w_state_nxt = r_sprite_state + 4'd1;
        end
      end else begin
        // Bases are multiples of 4, so OR-ing the wrapped offset is exact.
        w_state_nxt = base_of(r_mode) | {2'b00, r_sprite_state[1:0] + 2'd1};
        w_wrap_nxt  = w_loop_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode         <= IDLE;
      r_ret_mode     <= IDLE;
      r_sprite_state <= IDLE_BASE;
      r_anim_wrap    <= 1'b0;
    end else begin
      r_mode         <= w_mode_nxt;
      r_ret_mode     <= w_ret_nxt;
      r_sprite_state <= w_state_nxt;
      r_anim_wrap    <= w_wrap_nxt;
    end
  end

  assign sprite_state = r_sprite_state;
  assign anim_wrap    = r_anim_wrap;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench for sprite_anim_sequencer: one instance with
// FRAMES_PER_STEP=6, one with FRAMES_PER_STEP=1.
module tb_sprite_anim_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: FRAMES_PER_STEP = 6
  logic       reset0 = 1'b1;
  logic       frame_tick0 = 1'b0;
  logic       cmd_valid0 = 1'b0;
  logic [1:0] cmd0 = 2'd0;
  logic       cmd_ready0;
  logic [3:0] sprite_state0;
  logic       anim_wrap0;

  // Instance 1: FRAMES_PER_STEP = 1
  logic       reset1 = 1'b1;
  logic       frame_tick1 = 1'b0;
  logic       cmd_valid1 = 1'b0;
  logic [1:0] cmd1 = 2'd0;
  logic       cmd_ready1;
  logic [3:0] sprite_state1;
  logic       anim_wrap1;

  sprite_anim_sequencer #(.FRAMES_PER_STEP(6), .DIV_W(6)) dut0 (
    .clk          (clk),
    .reset        (reset0),
    .frame_tick   (frame_tick0),
    .cmd_valid    (cmd_valid0),
    .cmd          (cmd0),
    .cmd_ready    (cmd_ready0),
    .sprite_state (sprite_state0),
    .anim_wrap    (anim_wrap0)
  );

  sprite_anim_sequencer #(.FRAMES_PER_STEP(1), .DIV_W(6)) dut1 (
    .clk          (clk),
    .reset        (reset1),
    .frame_tick   (frame_tick1),
    .cmd_valid    (cmd_valid1),
    .cmd          (cmd1),
    .cmd_ready    (cmd_ready1),
    .sprite_state (sprite_state1),
    .anim_wrap    (anim_wrap1)
  );

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WALK = 2'd1;
  localparam logic [1:0] C_RUN  = 2'd2;
  localparam logic [1:0] C_JUMP = 2'd3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc0(input logic ft, input logic cv, input logic [1:0] c);
    frame_tick0 = ft; cmd_valid0 = cv; cmd0 = c;
    @(posedge clk); #1;
    frame_tick0 = 1'b0; cmd_valid0 = 1'b0;
  endtask

  task automatic cyc1(input logic rs, input logic ft, input logic cv, input logic [1:0] c);
    reset1 = rs; frame_tick1 = ft; cmd_valid1 = cv; cmd1 = c;
    @(posedge clk); #1;
    reset1 = 1'b0; frame_tick1 = 1'b0; cmd_valid1 = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset0 = 1'b1;
    cyc0(0, 0, C_IDLE);
    cyc0(0, 0, C_IDLE);
    reset0 = 1'b0;
    check("rst_state", sprite_state0, 0);
    check("rst_ready", cmd_ready0, 1);
    check("rst_wrap", anim_wrap0, 0);
    check("rst_mode", 32'(dut0.r_mode), 0);
    check("rst_ret", 32'(dut0.r_ret_mode), 0);
    check("rst_div", 32'(dut0.u_div.r_div_cnt), 0);

    // ---------------- 24 ticks in IDLE: 0,1,2,3,0 ----------------
    for (int i = 1; i <= 24; i++) begin
      cyc0(1, 0, C_IDLE);
      check($sformatf("idle_tick%0d_state", i), sprite_state0, (i / 6) % 4);
      check($sformatf("idle_tick%0d_wrap", i), anim_wrap0, (i == 24) ? 1 : 0);
      cyc0(0, 0, C_IDLE);
      check($sformatf("idle_gap%0d_wrap", i), anim_wrap0, 0);
    end

    // ---------------- advance to state 2, switch to WALK ----------------
    for (int i = 0; i < 12; i++) cyc0(1, 0, C_IDLE);
    check("idle_at2", sprite_state0, 2);
    cyc0(0, 1, C_WALK);
    check("walk_base", sprite_state0, 4);
    check("walk_div0", 32'(dut0.u_div.r_div_cnt), 0);
    check("walk_mode", 32'(dut0.r_mode), 1);
    for (int i = 0; i < 5; i++) cyc0(1, 0, C_IDLE);
    check("walk_5ticks", sprite_state0, 4);
    cyc0(1, 0, C_IDLE);
    check("walk_6ticks", sprite_state0, 5);

    // repeated WALK: no restart, divider kept
    cyc0(1, 0, C_IDLE);
    cyc0(1, 0, C_IDLE);
    check("walk_div2", 32'(dut0.u_div.r_div_cnt), 2);
    cyc0(0, 1, C_WALK);
    check("rewalk_state", sprite_state0, 5);
    check("rewalk_div", 32'(dut0.u_div.r_div_cnt), 2);
    for (int i = 0; i < 3; i++) cyc0(1, 0, C_IDLE);
    check("rewalk_3ticks", sprite_state0, 5);
    cyc0(1, 0, C_IDLE);
    check("rewalk_4ticks", sprite_state0, 6);

    // ---------------- RUN to state 9, then JUMP ----------------
    cyc0(0, 1, C_RUN);
    check("run_base", sprite_state0, 8);
    for (int i = 0; i < 6; i++) cyc0(1, 0, C_IDLE);
    check("run_at9", sprite_state0, 9);
    cyc0(0, 1, C_JUMP);
    check("jump_base", sprite_state0, 12);
    check("jump_ready", cmd_ready0, 0);
    check("jump_ret", 32'(dut0.r_ret_mode), 2);
    cyc0(0, 1, C_IDLE);
    check("jump_ignore_state", sprite_state0, 12);
    check("jump_ignore_mode", 32'(dut0.r_mode), 3);
    for (int i = 1; i <= 24; i++) begin
      cyc0(1, 0, C_IDLE);
      if (i == 6)  check("jump_t6", sprite_state0, 13);
      if (i == 12) check("jump_t12", sprite_state0, 14);
      if (i == 18) check("jump_t18", sprite_state0, 15);
      if (i == 23) check("jump_t23_ready", cmd_ready0, 0);
    end
    check("jump_end_state", sprite_state0, 8);
    check("jump_end_wrap", anim_wrap0, 1);
    check("jump_end_ready", cmd_ready0, 1);
    check("jump_end_mode", 32'(dut0.r_mode), 2);
    cyc0(0, 0, C_IDLE);
    check("jump_end_wrap_once", anim_wrap0, 0);

    // ---------------- command collides with 6th tick ----------------
    cyc0(0, 1, C_WALK);
    check("col_walk", sprite_state0, 4);
    for (int i = 0; i < 5; i++) cyc0(1, 0, C_IDLE);
    check("col_div5", 32'(dut0.u_div.r_div_cnt), 5);
    cyc0(1, 1, C_RUN);
    check("col_state", sprite_state0, 8);
    check("col_div0", 32'(dut0.u_div.r_div_cnt), 0);
    check("col_wrap", anim_wrap0, 0);
    for (int i = 0; i < 5; i++) cyc0(1, 0, C_IDLE);
    check("col_5ticks", sprite_state0, 8);
    cyc0(1, 0, C_IDLE);
    check("col_6ticks", sprite_state0, 9);
    cyc0(0, 1, C_IDLE);
    check("back_idle", sprite_state0, 0);

    // ---------------- FRAMES_PER_STEP=1, reset mid-jump ----------------
    cyc1(1, 0, 0, C_IDLE);
    check("f1_rst_state", sprite_state1, 0);
    cyc1(0, 1, 0, C_IDLE);
    check("f1_tick", sprite_state1, 1);
    cyc1(0, 0, 1, C_JUMP);
    check("f1_jump", sprite_state1, 12);
    cyc1(0, 1, 0, C_IDLE);
    check("f1_j13", sprite_state1, 13);
    cyc1(0, 1, 0, C_IDLE);
    check("f1_j14", sprite_state1, 14);
    check("f1_j14_ready", cmd_ready1, 0);
    cyc1(1, 1, 0, C_IDLE);
    check("f1_reset_state", sprite_state1, 0);
    check("f1_reset_mode", 32'(dut1.r_mode), 0);
    check("f1_reset_ret", 32'(dut1.r_ret_mode), 0);
    check("f1_reset_ready", cmd_ready1, 1);
    check("f1_reset_wrap", anim_wrap1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
